hotp_engine: RTL and testbench

Parametrised HMAC-SHA1 one-time-password sequencer and successor to the fixed 6-digit TOTP controller. It drives an external SHA-1 core through the four compressions, then does RFC 4226 dynamic truncation internally. The truncated value is converted to DIGITS BCD digits by an iterative converter. The key is a runtime port, and requests arriving while busy are queued.

---
 rtl/hotp_pkg.sv | 29 ++
 rtl/hotp_bcd_conv.sv | 49 ++++
 rtl/hotp_engine.sv | 146 ++++++++++++++
 tb/tb_hotp_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hotp_pkg.sv
// Shared types and constants for the HMAC-SHA1 one-time-password engine.
// Optional watchdog in hotp_engine is enabled by defining HOTP_TIMEOUT_EN.
package hotp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_INIT_I, ST_WAIT_I, ST_NEXT_M, ST_WAIT_M, ST_INIT_O,
        ST_WAIT_O, ST_NEXT_D, ST_WAIT_D, ST_TRUNC, ST_CONV, ST_DONE
    } state_t;

    localparam logic [7:0]  IPAD       = 8'h36;
    localparam logic [7:0]  OPAD       = 8'h5c;
    localparam logic [63:0] LEN_M      = 64'd576;   // 64-byte ipad block + 8-byte counter
    localparam logic [63:0] LEN_D      = 64'd672;   // 64-byte opad block + 20-byte digest
    localparam int          BCD_DIGITS = 10;
    localparam int          BIN_W      = 31;

    function automatic logic [7:0] dig_byte(input logic [159:0] dig, input logic [4:0] k);
        return dig[159 - 8*int'(k) -: 8];
    endfunction

    // Dynamic truncation: four bytes starting at the offset in the last nibble, sign bit dropped.
    function automatic logic [BIN_W-1:0] hotp_trunc(input logic [159:0] dig);
        logic [4:0] off;
        off = {1'b0, dig[3:0]};
        return BIN_W'({dig_byte(dig, off), dig_byte(dig, off + 5'd1),
                       dig_byte(dig, off + 5'd2), dig_byte(dig, off + 5'd3)} & 32'h7fff_ffff);
    endfunction

endpackage

// File: rtl/hotp_bcd_conv.sv
// Iterative double-dabble: 31-bit binary to 10 BCD digits, one bit per cycle MSB first.
module hotp_bcd_conv
    import hotp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [BIN_W-1:0]        bin,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    done
);

    logic                    run_q;
    logic [4:0]              cnt_q;
    logic [BIN_W-1:0]        sr_q;
    logic [4*BCD_DIGITS-1:0] bcd_q, adj;
    logic                    unused_top;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    // Result is presented combinationally alongside done so the caller can capture it that cycle.
    assign bcd        = {adj[4*BCD_DIGITS-2:0], sr_q[BIN_W-1]};
    assign unused_top = adj[4*BCD_DIGITS-1];
    assign done       = run_q && (cnt_q == 5'(BIN_W-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            sr_q  <= '0;
            bcd_q <= '0;
        end else if (load) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            sr_q  <= bin;
            bcd_q <= '0;
        end else if (run_q) begin
            bcd_q <= bcd;
            sr_q  <= {sr_q[BIN_W-2:0], 1'b0};
            cnt_q <= cnt_q + 5'd1;
            if (done) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/hotp_engine.sv
// HMAC-SHA1 HOTP sequencer: drives an external SHA-1 core, truncates and converts to BCD.
// Define HOTP_TIMEOUT_EN to add a per-wait watchdog with a sticky error flag.
module hotp_engine
    import hotp_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                time_up,
    input  logic [63:0]         counter_in,
    input  logic [511:0]        key_in,
    output logic                sha1_init,
    output logic                sha1_next,
    output logic [511:0]        sha1_block,
    input  logic                sha1_ready,
    input  logic [159:0]        sha1_digest,
    output logic                busy,
    output logic [4*DIGITS-1:0] code,
    output logic                code_valid,
    output logic                error
);

    localparam int CODE_W = 4*DIGITS;

    if (DIGITS < 1 || DIGITS > 9 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("hotp_engine: DIGITS must be 1..9 and TIMEOUT_CYCLES >= 2");
    end

    state_t                  state, state_nx;
    logic                    pend_q, guard_q, conv_ld;
    logic [511:0]            key_q, blk_q;
    logic [63:0]             ctr_q;
    logic [159:0]            inner_q;
    logic [BIN_W-1:0]        trunc_q;
    logic [CODE_W-1:0]       code_q;
    logic                    in_wait, adv, wd_trip, conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;
    logic                    unused_bcd;

    assign in_wait = state inside {ST_WAIT_I, ST_WAIT_M, ST_WAIT_O, ST_WAIT_D};
    // The core still shows the previous ready in the cycle right after a pulse.
    assign adv     = in_wait && !guard_q && sha1_ready;

`ifdef HOTP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;

    assign wd_trip = in_wait && !adv && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign error   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= in_wait ? wd_q + 1'b1 : '0;
            if (wd_trip) err_q <= 1'b1;
        end
    end
`else
    assign wd_trip = 1'b0;
    assign error   = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        sha1_init  = 1'b0;
        sha1_next  = 1'b0;
        busy       = 1'b1;
        code_valid = 1'b0;
        case (state)
            ST_IDLE:   begin busy = 1'b0; if (time_up || pend_q) state_nx = ST_INIT_I; end
            ST_INIT_I: begin sha1_init = 1'b1; state_nx = ST_WAIT_I; end
            ST_WAIT_I: if (adv) state_nx = ST_NEXT_M;
            ST_NEXT_M: begin sha1_next = 1'b1; state_nx = ST_WAIT_M; end
            ST_WAIT_M: if (adv) state_nx = ST_INIT_O;
            ST_INIT_O: begin sha1_init = 1'b1; state_nx = ST_WAIT_O; end
            ST_WAIT_O: if (adv) state_nx = ST_NEXT_D;
            ST_NEXT_D: begin sha1_next = 1'b1; state_nx = ST_WAIT_D; end
            ST_WAIT_D: if (adv) state_nx = ST_TRUNC;
            ST_TRUNC:  state_nx = ST_CONV;
            ST_CONV:   if (conv_done) state_nx = ST_DONE;
            ST_DONE:   begin busy = 1'b0; code_valid = 1'b1; state_nx = ST_IDLE; end
            default:   state_nx = ST_IDLE;
        endcase
        if (wd_trip) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            guard_q <= 1'b0;
            conv_ld <= 1'b0;
            key_q   <= '0;
            ctr_q   <= '0;
            inner_q <= '0;
            trunc_q <= '0;
            code_q  <= '0;
            blk_q   <= '0;
        end else begin
            if (state == ST_IDLE) pend_q <= 1'b0;
            else if (time_up)     pend_q <= 1'b1;
            if (state == ST_IDLE && state_nx == ST_INIT_I) begin
                key_q <= key_in;
                ctr_q <= counter_in;
            end
            if (state == ST_INIT_O) inner_q <= sha1_digest;
            if (state == ST_TRUNC)  trunc_q <= hotp_trunc(sha1_digest);
            conv_ld <= (state == ST_TRUNC);
            guard_q <= sha1_init || sha1_next;
            if (conv_done) code_q <= conv_bcd[CODE_W-1:0];
            // Block is set on entry to each issue state and then held through the wait.
            if (state_nx != state) begin
                case (state_nx)
                    ST_INIT_I: blk_q <= key_in ^ {64{IPAD}};
                    ST_NEXT_M: blk_q <= {ctr_q, 1'b1, 383'b0, LEN_M};
                    ST_INIT_O: blk_q <= key_q ^ {64{OPAD}};
                    ST_NEXT_D: blk_q <= {inner_q, 1'b1, 287'b0, LEN_D};
                    default:   ;
                endcase
            end
        end
    end

    hotp_bcd_conv u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (conv_ld),
        .bin   (trunc_q),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    assign unused_bcd = ^conv_bcd[4*BCD_DIGITS-1:CODE_W];
    assign sha1_block = blk_q;
    assign code       = code_q;

endmodule

// File: tb/tb_hotp_engine.sv
// Bench for hotp_engine: DIGITS=6 and DIGITS=8 instances, each with a behavioural SHA-1 core.
module tb_hotp_engine;

    localparam logic [159:0] H0      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [511:0] RFC_KEY = {160'h3132333435363738393031323334353637383930, 352'h0};

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            time_up, s_init, s_next, s_ready, busy, cv, err;
    logic [1:0][63:0]      ctr_in;
    logic [1:0][511:0]     key_in, s_blk;
    logic [1:0][159:0]     s_dig, st;
    logic [23:0]           code6;
    logic [31:0]           code8;
    bit   [1:0]            stall;
    int                    lat_left[2];
    int                    cv_cnt[2];
    int                    checks = 0, errors = 0;

    always #5 clk = ~clk;

    hotp_engine #(.DIGITS(6), .TIMEOUT_CYCLES(64)) u6 (
        .clk(clk), .rst_n(rst_n), .time_up(time_up[0]), .counter_in(ctr_in[0]), .key_in(key_in[0]),
        .sha1_init(s_init[0]), .sha1_next(s_next[0]), .sha1_block(s_blk[0]), .sha1_ready(s_ready[0]),
        .sha1_digest(s_dig[0]), .busy(busy[0]), .code(code6), .code_valid(cv[0]), .error(err[0]));

    hotp_engine #(.DIGITS(8), .TIMEOUT_CYCLES(64)) u8 (
        .clk(clk), .rst_n(rst_n), .time_up(time_up[1]), .counter_in(ctr_in[1]), .key_in(key_in[1]),
        .sha1_init(s_init[1]), .sha1_next(s_next[1]), .sha1_block(s_blk[1]), .sha1_ready(s_ready[1]),
        .sha1_digest(s_dig[1]), .busy(busy[1]), .code(code8), .code_valid(cv[1]), .error(err[1]));

    function automatic logic [159:0] sha1_cmp(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w[80];
        logic [31:0] a, b, c, d, e, f, k, t, x;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        {a, b, c, d, e} = h;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // HMAC-SHA1 with standard message padding, truncation, then decimal digits by division.
    function automatic logic [35:0] hotp_ref(input logic [511:0] key, input logic [63:0] c, input int digits);
        logic [159:0] inner, mac;
        logic [7:0]   by[20];
        logic [31:0]  bin;
        longint       v, p;
        int           off;
        logic [35:0]  r;
        inner = sha1_cmp(sha1_cmp(H0, key ^ {64{8'h36}}), {c, 8'h80, 376'h0, 64'd576});
        mac   = sha1_cmp(sha1_cmp(H0, key ^ {64{8'h5c}}), {inner, 8'h80, 280'h0, 64'd672});
        for (int i = 0; i < 20; i++) by[i] = mac[159-8*i -: 8];
        off = int'(mac[3:0]);
        bin = {by[off], by[off+1], by[off+2], by[off+3]} & 32'h7fff_ffff;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        v = longint'(bin) % p;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Behavioural SHA-1 core: random latency, optional indefinite stall.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready <= '1;
            s_dig   <= '0;
            st      <= '0;
            lat_left[0] <= 0;
            lat_left[1] <= 0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (s_init[g] || s_next[g]) begin
                    st[g]       <= sha1_cmp(s_init[g] ? H0 : st[g], s_blk[g]);
                    s_ready[g]  <= 1'b0;
                    lat_left[g] <= int'($urandom_range(6, 1));
                end else if (lat_left[g] > 1) begin
                    lat_left[g] <= lat_left[g] - 1;
                end else if (lat_left[g] == 1 && !stall[g]) begin
                    lat_left[g] <= 0;
                    s_ready[g]  <= 1'b1;
                    s_dig[g]    <= st[g];
                end
            end
        end
    end

    always @(negedge clk) for (int g = 0; g < 2; g++) if (cv[g] === 1'b1) cv_cnt[g]++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cv(input int u, output logic [35:0] got, output bit to);
        int n = 0;
        while (cv[u] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        to  = (cv[u] !== 1'b1);
        got = (u == 0) ? {12'h0, code6} : {4'h0, code8};
    endtask

    task automatic run_one(input int u, input logic [63:0] c, input logic [511:0] k,
                           output logic [35:0] got, output bit to);
        @(negedge clk);
        ctr_in[u] = c; key_in[u] = k; time_up[u] = 1'b1;
        @(negedge clk);
        time_up[u] = 1'b0;
        wait_cv(u, got, to);
    endtask

    // Called at the DONE negedge: checks code, busy, and that exactly one pulse was seen.
    task automatic check_run(input string name, input int u, input logic [35:0] got, input bit to,
                             input logic [35:0] exp, input int base);
        chk({name, "_code"}, 64'(got), 64'(exp));
        chk({name, "_timeout"}, 64'(to), 64'd0);
        chk({name, "_busy_done"}, 64'(busy[u]), 64'd0);
        @(negedge clk);
        chk({name, "_busy_after"}, 64'(busy[u]), 64'd0);
        chk({name, "_pulses"}, 64'(cv_cnt[u] - base), 64'd1);
    endtask

    typedef struct { int u; logic [63:0] c; logic [35:0] exp; } vec_t;
    vec_t vt[14];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [35:0]  got, got2;
        logic [511:0] k;
        logic [63:0]  c1, c2;
        bit           to, saw;
        int           base, n;

        vt[0]  = '{0, 64'd0, 36'h755224};   vt[1]  = '{0, 64'd1, 36'h287082};
        vt[2]  = '{0, 64'd2, 36'h359152};   vt[3]  = '{0, 64'd3, 36'h969429};
        vt[4]  = '{0, 64'd4, 36'h338314};   vt[5]  = '{0, 64'd5, 36'h254676};
        vt[6]  = '{0, 64'd6, 36'h287922};   vt[7]  = '{0, 64'd7, 36'h162583};
        vt[8]  = '{0, 64'd8, 36'h399871};   vt[9]  = '{0, 64'd9, 36'h520489};
        vt[10] = '{1, 64'd1, 36'h94287082}; vt[11] = '{1, 64'd0, 36'h84755224};
        vt[12] = '{1, 64'd5, 36'h68254676}; vt[13] = '{1, 64'd9, 36'h45520489};

        rst_n = 1'b0; time_up = '0; ctr_in = '0; key_in = '0; stall = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_code_valid", 64'(cv), 64'd0);
        chk("rst_code6", 64'(code6), 64'd0);
        chk("rst_code8", 64'(code8), 64'd0);
        chk("rst_pulses", 64'({s_init, s_next}), 64'd0);
        chk("rst_block_zero", 64'(s_blk == '0), 64'd1);
        chk("rst_error", 64'(err), 64'd0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            base = cv_cnt[vt[i].u];
            run_one(vt[i].u, vt[i].c, RFC_KEY, got, to);
            check_run($sformatf("rfc%0d_c%0d", vt[i].u ? 8 : 6, vt[i].c), vt[i].u, got, to, vt[i].exp, base);
        end

        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < 16; w++) k[32*w +: 32] = $urandom;
            c1 = {$urandom, $urandom};
            base = cv_cnt[i % 2];
            run_one(i % 2, c1, k, got, to);
            check_run($sformatf("rand%0d", i), i % 2, got, to, hotp_ref(k, c1, (i % 2) ? 8 : 6), base);
        end

        // Three extra requests during a run: one is held, the rest dropped.
        c1 = {$urandom, $urandom}; c2 = {$urandom, $urandom};
        base = cv_cnt[0];
        @(negedge clk); ctr_in[0] = c1; key_in[0] = RFC_KEY; time_up[0] = 1'b1;
        @(negedge clk); time_up[0] = 1'b0;
        repeat (5) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            ctr_in[0] = {$urandom, $urandom}; time_up[0] = 1'b1;
            @(negedge clk); time_up[0] = 1'b0;
            repeat (3) @(negedge clk);
        end
        ctr_in[0] = c2;
        wait_cv(0, got, to);
        check_run("pend_first", 0, got, to, hotp_ref(RFC_KEY, c1, 6), base);
        wait_cv(0, got, to);
        check_run("pend_second", 0, got, to, hotp_ref(RFC_KEY, c2, 6), base + 1);
        repeat (300) @(negedge clk);
        chk("pend_total_pulses", 64'(cv_cnt[0] - base), 64'd2);

        // Request arriving in the DONE cycle is held and served next.
        base = cv_cnt[0];
        run_one(0, 64'd3, RFC_KEY, got, to);
        ctr_in[0] = 64'd7; time_up[0] = 1'b1;
        chk("done_req_first", 64'(got), 64'h969429);
        @(negedge clk); time_up[0] = 1'b0;
        wait_cv(0, got2, to);
        check_run("done_req_second", 0, got2, to, 36'h162583, base + 1);

        // Reset in WAIT_M with a request pending.
        base = cv_cnt[0];
        @(negedge clk); ctr_in[0] = 64'd5; time_up[0] = 1'b1;
        @(negedge clk); time_up[0] = 1'b1;
        @(negedge clk); time_up[0] = 1'b0;
        n = 0;
        while (s_next[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("rst_mid_reached_next", 64'(s_next[0]), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy[0]), 64'd0);
        chk("rst_mid_code", 64'(code6), 64'd0);
        chk("rst_mid_pulses", 64'({s_init[0], s_next[0], cv[0]}), 64'd0);
        chk("rst_mid_block_zero", 64'(s_blk[0] == '0), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        saw = 1'b0;
        repeat (60) begin @(negedge clk); if (busy[0] !== 1'b0) saw = 1'b1; end
        chk("rst_mid_no_pending", 64'(saw), 64'd0);
        chk("rst_mid_no_code_valid", 64'(cv_cnt[0] - base), 64'd0);
        base = cv_cnt[0];
        run_one(0, 64'd0, RFC_KEY, got, to);
        check_run("rst_mid_rerun", 0, got, to, 36'h755224, base);

`ifdef HOTP_TIMEOUT_EN
        base = cv_cnt[0];
        got2 = {12'h0, code6};
        stall[0] = 1'b1;
        @(negedge clk); ctr_in[0] = 64'd1; time_up[0] = 1'b1;
        @(negedge clk); time_up[0] = 1'b0;
        n = 1;
        while (err[0] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        chk("wd_error", 64'(err[0]), 64'd1);
        chk("wd_cycles_to_error", 64'(n), 64'd66);
        chk("wd_idle", 64'(busy[0]), 64'd0);
        repeat (5) @(negedge clk);
        chk("wd_no_code_valid", 64'(cv_cnt[0] - base), 64'd0);
        chk("wd_code_kept", 64'({12'h0, code6}), 64'(got2));
        stall[0] = 1'b0;
        repeat (3) @(negedge clk);
        base = cv_cnt[0];
        run_one(0, 64'd2, RFC_KEY, got, to);
        check_run("wd_after", 0, got, to, 36'h359152, base);
        chk("wd_error_sticky", 64'(err[0]), 64'd1);
`else
        chk("error_tied_low", 64'(err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
